// File: rtl/i2c_cmd_arbiter.sv
// ---------------------------------------------------------------------------
// i2c_cmd_arbiter
//
// Shares one I2C byte controller between NUM_REQ requesters (for example the
// clock-chip config loader and a status poller). Ownership is granted
// round-robin and stays locked for a whole START..STOP transaction. The
// owner's byte command is latched and held stable towards the byte controller
// until it acknowledges, and the response is routed back to the owner as a
// one-cycle done pulse. If the owner drops its request, or stays idle for
// TIMEOUT cycles, the arbiter releases the bus itself and issues a STOP when
// the bus was left open.
//
// Ports
//   clk_i, rst_i            clock, synchronous active-high reset
//   req_i[NUM_REQ]          per-requester level request
//   grant_o[NUM_REQ]        one-hot ownership
//   cmd_ready_o[NUM_REQ]    owner may present a command
//   cmd_valid_i[NUM_REQ]    one-cycle command strobe
//   cmd_start_i/stop_i/read_i/write_i/ack_in_i[NUM_REQ]  command fields
//   cmd_din_i[NUM_REQ*DATA_WIDTH]  write bytes, requester k at k*DATA_WIDTH
//   done_o[NUM_REQ]         one-cycle completion pulse to the owner
//   err_o                   arbitration lost, valid with done_o
//   rsp_dout_o, rsp_ack_o   read byte / slave ACK, valid with done_o
//   timeout_o               one-cycle pulse on watchdog revoke
//   start_o/stop_o/read_o/write_o/ack_in_o, din_o   to byte controller
//   cmd_ack_i, ack_out_i, al_i, dout_i              from byte controller
// ---------------------------------------------------------------------------
module i2c_cmd_arbiter #(
  parameter int NUM_REQ    = 2,
  parameter int DATA_WIDTH = 8,
  parameter int TIMEOUT    = 1024,
  parameter int GAP_CYCLES = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [NUM_REQ-1:0]            req_i,
  output logic [NUM_REQ-1:0]            grant_o,
  output logic [NUM_REQ-1:0]            cmd_ready_o,
  input  logic [NUM_REQ-1:0]            cmd_valid_i,
  input  logic [NUM_REQ-1:0]            cmd_start_i,
  input  logic [NUM_REQ-1:0]            cmd_stop_i,
  input  logic [NUM_REQ-1:0]            cmd_read_i,
  input  logic [NUM_REQ-1:0]            cmd_write_i,
  input  logic [NUM_REQ-1:0]            cmd_ack_in_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] cmd_din_i,
  output logic [NUM_REQ-1:0]            done_o,
  output logic                          err_o,
  output logic [DATA_WIDTH-1:0]         rsp_dout_o,
  output logic                          rsp_ack_o,
  output logic                          timeout_o,
  output logic                          start_o,
  output logic                          stop_o,
  output logic                          read_o,
  output logic                          write_o,
  output logic                          ack_in_o,
  output logic [DATA_WIDTH-1:0]         din_o,
  input  logic                          cmd_ack_i,
  input  logic                          ack_out_i,
  input  logic                          al_i,
  input  logic [DATA_WIDTH-1:0]         dout_i
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int WD_W  = $clog2(TIMEOUT + 1);
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_OWNED      = 3'd1,
    S_ISSUE      = 3'd2,
    S_FORCE_STOP = 3'd3,
    S_GAP        = 3'd4
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;

  logic [NUM_REQ-1:0]      r_grant;
  logic [PTR_W-1:0]        r_owner;
  logic [PTR_W-1:0]        r_rr_ptr;
  logic                    r_bus_open;
  logic [WD_W-1:0]         r_wdog;
  logic [GAP_W-1:0]        r_gap_cnt;
  // Requesters revoked by the watchdog stay masked until they drop req.
  logic [NUM_REQ-1:0]      r_blocked;

  logic                    r_start;
  logic                    r_stop;
  logic                    r_read;
  logic                    r_write;
  logic                    r_ack_in;
  logic [DATA_WIDTH-1:0]   r_din;

  logic [NUM_REQ-1:0]      r_done;
  logic                    r_err;
  logic [DATA_WIDTH-1:0]   r_rsp_dout;
  logic                    r_rsp_ack;
  logic                    r_timeout;

  // Arbitration
  logic [NUM_REQ-1:0]      w_elig;
  logic [2*NUM_REQ-1:0]    w_rot;
  logic                    w_found;
  logic [PTR_W-1:0]        w_winner;
  logic [PTR_W-1:0]        w_rr_nxt;
  logic [NUM_REQ-1:0]      w_win_onehot;

  // Owner's view of the request/command inputs
  logic                    w_own_req;
  logic                    w_own_valid;
  logic                    w_sel_start;
  logic                    w_sel_stop;
  logic                    w_sel_read;
  logic                    w_sel_write;
  logic                    w_sel_ack_in;
  logic [DATA_WIDTH-1:0]   w_sel_din;

  // FSM strobes
  logic                    w_wdog_expire;
  logic                    w_grant_take;
  logic                    w_cmd_accept;
  logic                    w_cmd_done;
  logic                    w_cmd_abort;
  logic                    w_release;
  logic                    w_timeout_fire;
  logic                    w_fs_done;

  // -------------------------------------------------------------------------
  // Round-robin pick: rotate the eligible vector so rr_ptr sits at bit 0,
  // then the first set bit is the winner's distance from rr_ptr.
  // -------------------------------------------------------------------------
  assign w_elig = req_i & ~r_blocked;
  assign w_rot  = {w_elig, w_elig} >> r_rr_ptr;

  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!w_found && w_rot[i]) begin
        w_found  = 1'b1;
        w_winner = PTR_W'((int'(r_rr_ptr) + i) % NUM_REQ);
      end
    end
  end

  assign w_rr_nxt     = (w_winner == PTR_W'(NUM_REQ - 1)) ? '0 : w_winner + PTR_W'(1);
  assign w_win_onehot = NUM_REQ'(1) << w_winner;

  // Owner mux built as a compare loop so a non-power-of-two NUM_REQ never
  // indexes past the request vectors.
  always_comb begin
    w_own_req    = 1'b0;
    w_own_valid  = 1'b0;
    w_sel_start  = 1'b0;
    w_sel_stop   = 1'b0;
    w_sel_read   = 1'b0;
    w_sel_write  = 1'b0;
    w_sel_ack_in = 1'b0;
    w_sel_din    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (r_owner == PTR_W'(k)) begin
        w_own_req    = req_i[k];
        w_own_valid  = cmd_valid_i[k];
        w_sel_start  = cmd_start_i[k];
        w_sel_stop   = cmd_stop_i[k];
        w_sel_read   = cmd_read_i[k];
        w_sel_write  = cmd_write_i[k];
        w_sel_ack_in = cmd_ack_in_i[k];
        w_sel_din    = cmd_din_i[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Counter value TIMEOUT-1 means this is the TIMEOUT-th idle owned cycle.
  assign w_wdog_expire = (r_wdog == WD_W'(TIMEOUT - 1));

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    w_state_nxt    = r_state;
    w_grant_take   = 1'b0;
    w_cmd_accept   = 1'b0;
    w_cmd_done     = 1'b0;
    w_cmd_abort    = 1'b0;
    w_release      = 1'b0;
    w_timeout_fire = 1'b0;
    w_fs_done      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_grant_take = 1'b1;
          w_state_nxt  = S_OWNED;
        end
      end
      S_OWNED: begin
        // A request drop wins over a same-cycle command; a command wins over
        // the watchdog because it counts as activity.
        if (!w_own_req) begin
          w_release   = 1'b1;
          w_state_nxt = r_bus_open ? S_FORCE_STOP : S_GAP;
        end else if (w_own_valid) begin
          w_cmd_accept = 1'b1;
          w_state_nxt  = S_ISSUE;
        end else if (w_wdog_expire) begin
          w_release      = 1'b1;
          w_timeout_fire = 1'b1;
          w_state_nxt    = r_bus_open ? S_FORCE_STOP : S_GAP;
        end
      end
      S_ISSUE: begin
        if (al_i) begin
          w_cmd_abort = 1'b1;
          w_state_nxt = S_OWNED;
        end else if (cmd_ack_i) begin
          w_cmd_done  = 1'b1;
          w_state_nxt = S_OWNED;
        end
      end
      S_FORCE_STOP: begin
        if (cmd_ack_i || al_i) begin
          w_fs_done   = 1'b1;
          w_state_nxt = S_GAP;
        end
      end
      S_GAP: begin
        if (r_gap_cnt == GAP_W'(GAP_CYCLES - 1)) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // State and datapath registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= S_IDLE;
      r_grant    <= '0;
      r_owner    <= '0;
      r_rr_ptr   <= '0;
      r_bus_open <= 1'b0;
      r_wdog     <= '0;
      r_gap_cnt  <= '0;
      r_blocked  <= '0;
      r_start    <= 1'b0;
      r_stop     <= 1'b0;
      r_read     <= 1'b0;
      r_write    <= 1'b0;
      r_ack_in   <= 1'b0;
      r_din      <= '0;
      r_done     <= '0;
      r_err      <= 1'b0;
      r_rsp_dout <= '0;
      r_rsp_ack  <= 1'b0;
      r_timeout  <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_done    <= '0;
      r_err     <= 1'b0;
      r_timeout <= 1'b0;
      r_blocked <= (r_blocked & req_i) | (w_timeout_fire ? r_grant : '0);

      if (w_grant_take) begin
        r_grant  <= w_win_onehot;
        r_owner  <= w_winner;
        r_rr_ptr <= w_rr_nxt;
        r_wdog   <= '0;
      end

      if (r_state == S_OWNED) begin
        r_wdog <= w_cmd_accept ? '0 : r_wdog + WD_W'(1);
      end

      if (w_cmd_accept) begin
        r_start  <= w_sel_start;
        r_stop   <= w_sel_stop;
        r_read   <= w_sel_read;
        r_write  <= w_sel_write;
        r_ack_in <= w_sel_ack_in;
        r_din    <= w_sel_din;
      end

      if (w_cmd_done || w_cmd_abort) begin
        r_start    <= 1'b0;
        r_stop     <= 1'b0;
        r_read     <= 1'b0;
        r_write    <= 1'b0;
        r_ack_in   <= 1'b0;
        r_din      <= '0;
        r_done     <= r_grant;
        r_err      <= w_cmd_abort;
        r_rsp_dout <= dout_i;
        r_rsp_ack  <= ack_out_i;
        r_wdog     <= '0;
        // A lost arbitration leaves the bus closed; otherwise STOP wins over
        // START when a command carries both.
        if (w_cmd_abort || r_stop) begin
          r_bus_open <= 1'b0;
        end else if (r_start) begin
          r_bus_open <= 1'b1;
        end
      end

      if (w_release) begin
        r_grant   <= '0;
        r_gap_cnt <= '0;
        if (w_timeout_fire) begin
          r_timeout <= 1'b1;
        end
        if (r_bus_open) begin
          r_start  <= 1'b0;
          r_stop   <= 1'b1;
          r_read   <= 1'b0;
          r_write  <= 1'b0;
          r_ack_in <= 1'b1;
          r_din    <= '0;
        end
      end

      if (w_fs_done) begin
        r_stop     <= 1'b0;
        r_ack_in   <= 1'b0;
        r_bus_open <= 1'b0;
        r_gap_cnt  <= '0;
      end

      if (r_state == S_GAP) begin
        r_gap_cnt <= r_gap_cnt + GAP_W'(1);
      end
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign grant_o     = r_grant;
  assign cmd_ready_o = (r_state == S_OWNED) ? r_grant : '0;
  assign done_o      = r_done;
  assign err_o       = r_err;
  assign rsp_dout_o  = r_rsp_dout;
  assign rsp_ack_o   = r_rsp_ack;
  assign timeout_o   = r_timeout;
  assign start_o     = r_start;
  assign stop_o      = r_stop;
  assign read_o      = r_read;
  assign write_o     = r_write;
  assign ack_in_o    = r_ack_in;
  assign din_o       = r_din;

endmodule

// File: tb/tb_i2c_cmd_arbiter.sv
// ---------------------------------------------------------------------------
// Directed testbench for i2c_cmd_arbiter (NUM_REQ=2, TIMEOUT=16, GAP=4).
// Inputs are driven 1 time unit after each rising edge and outputs are
// sampled at the same point, so every check sees the state registered on
// the edge just passed.
// ---------------------------------------------------------------------------
module tb_i2c_cmd_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req, cmd_valid, cmd_start, cmd_stop, cmd_read, cmd_write, cmd_ack_in;
  logic [15:0] cmd_din;
  logic [1:0]  grant, cmd_ready, done;
  logic        err, rsp_ack, timeout;
  logic [7:0]  rsp_dout, din_o, dout;
  logic        start_o, stop_o, read_o, write_o, ack_in_o;
  logic        cmd_ack, ack_out, al;

  int n_cmp = 0;
  int n_mis = 0;

  i2c_cmd_arbiter #(
    .NUM_REQ(2), .DATA_WIDTH(8), .TIMEOUT(16), .GAP_CYCLES(4)
  ) dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .grant_o(grant), .cmd_ready_o(cmd_ready),
    .cmd_valid_i(cmd_valid), .cmd_start_i(cmd_start), .cmd_stop_i(cmd_stop),
    .cmd_read_i(cmd_read), .cmd_write_i(cmd_write), .cmd_ack_in_i(cmd_ack_in),
    .cmd_din_i(cmd_din), .done_o(done), .err_o(err), .rsp_dout_o(rsp_dout),
    .rsp_ack_o(rsp_ack), .timeout_o(timeout), .start_o(start_o), .stop_o(stop_o),
    .read_o(read_o), .write_o(write_o), .ack_in_o(ack_in_o), .din_o(din_o),
    .cmd_ack_i(cmd_ack), .ack_out_i(ack_out), .al_i(al), .dout_i(dout)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present one command from requester k for a single cycle.
  task automatic send(input int k, input logic s, input logic p, input logic r,
                      input logic w, input logic [7:0] d);
    cmd_valid[k]      = 1'b1;
    cmd_start[k]      = s;
    cmd_stop[k]       = p;
    cmd_read[k]       = r;
    cmd_write[k]      = w;
    cmd_din[k*8 +: 8] = d;
    tick(1);
    cmd_valid = '0; cmd_start = '0; cmd_stop = '0;
    cmd_read  = '0; cmd_write = '0; cmd_din  = '0;
  endtask

  // {start, stop, read, write, ack_in} towards the byte controller
  function automatic logic [4:0] bus_cmd();
    return {start_o, stop_o, read_o, write_o, ack_in_o};
  endfunction

  initial begin
    #200000;
    $display("FAIL sim_time_limit: observed=expired expected=finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; req = '0; cmd_valid = '0; cmd_start = '0; cmd_stop = '0;
    cmd_read = '0; cmd_write = '0; cmd_ack_in = '0; cmd_din = '0;
    cmd_ack = 1'b0; ack_out = 1'b0; al = 1'b0; dout = '0;
    tick(2);
    chk("rst_grant", grant, 0);
    chk("rst_ready", cmd_ready, 0);
    chk("rst_done", done, 0);
    chk("rst_cmd", bus_cmd(), 0);
    chk("rst_din", din_o, 0);
    chk("rst_flags", {err, rsp_ack, timeout}, 0);
    chk("rst_rsp", rsp_dout, 0);
    rst = 1'b0;
    tick(1);

    // Requester 0 alone: start+write, write, write+stop
    req = 2'b01;
    chk("s1_pre_grant", grant, 0);
    tick(1);
    chk("s1_grant", grant, 2'b01);
    chk("s1_ready", cmd_ready, 2'b01);
    send(0, 1, 0, 0, 1, 8'hE8);
    chk("s1c1_cmd", bus_cmd(), 5'b10010);
    chk("s1c1_din", din_o, 8'hE8);
    chk("s1c1_ready_busy", cmd_ready, 0);
    tick(4);
    chk("s1c1_hold_cmd", bus_cmd(), 5'b10010);
    chk("s1c1_hold_din", din_o, 8'hE8);
    dout = 8'h5A; ack_out = 1'b0; cmd_ack = 1'b1;
    tick(1);
    cmd_ack = 1'b0;
    chk("s1c1_done", done, 2'b01);
    chk("s1c1_err", err, 0);
    chk("s1c1_rsp", rsp_dout, 8'h5A);
    chk("s1c1_rsp_ack", rsp_ack, 0);
    chk("s1c1_cleared", bus_cmd(), 0);
    tick(1);
    chk("s1c1_done_pulse", done, 0);
    chk("s1c1_ready_again", cmd_ready, 2'b01);

    send(0, 0, 0, 0, 1, 8'h01);
    chk("s1c2_cmd", bus_cmd(), 5'b00010);
    chk("s1c2_din", din_o, 8'h01);
    tick(4);
    chk("s1c2_hold", {bus_cmd(), din_o}, {5'b00010, 8'h01});
    dout = 8'hC3; ack_out = 1'b1; cmd_ack = 1'b1;
    tick(1);
    cmd_ack = 1'b0;
    chk("s1c2_done", done, 2'b01);
    chk("s1c2_rsp", rsp_dout, 8'hC3);
    chk("s1c2_rsp_ack", rsp_ack, 1);

    send(0, 0, 1, 0, 1, 8'h0B);
    chk("s1c3_cmd", bus_cmd(), 5'b01010);
    chk("s1c3_din", din_o, 8'h0B);
    tick(4);
    chk("s1c3_hold", {bus_cmd(), din_o}, {5'b01010, 8'h0B});
    cmd_ack = 1'b1; ack_out = 1'b0;
    tick(1);
    cmd_ack = 1'b0;
    chk("s1c3_done", done, 2'b01);
    chk("s1c3_cleared", bus_cmd(), 0);
    tick(1);
    // Bus closed by the stop, so a request drop goes straight to GAP.
    req = 2'b00;
    tick(1);
    chk("s1_release_grant", grant, 0);
    chk("s1_release_nostop", stop_o, 0);
    req = 2'b01;
    tick(4);
    chk("s1_gap_hold", grant, 0);
    tick(1);
    chk("s1_regrant", grant, 2'b01);

    // Round-robin between two requesters
    rst = 1'b1; req = 2'b00;
    tick(1);
    rst = 1'b0;
    req = 2'b11;
    tick(1);
    chk("s2_first", grant, 2'b01);
    req = 2'b10;
    tick(1);
    chk("s2_gap0", grant, 0);
    tick(4);
    chk("s2_gap0_hold", grant, 0);
    tick(1);
    chk("s2_second", grant, 2'b10);
    req = 2'b01;
    tick(1);
    req = 2'b11;
    tick(4);
    chk("s2_gap1_hold", grant, 0);
    tick(1);
    chk("s2_third", grant, 2'b01);
    req = 2'b10;
    tick(1);
    req = 2'b11;
    tick(5);
    chk("s2_fourth", grant, 2'b10);

    // Requester 1 drops out with the bus open; requester 0 waits.
    send(1, 1, 0, 0, 1, 8'hA0);
    chk("s3_cmd", bus_cmd(), 5'b10010);
    chk("s3_din", din_o, 8'hA0);
    chk("s3_no_preempt", grant, 2'b10);
    tick(2);
    cmd_ack = 1'b1;
    tick(1);
    cmd_ack = 1'b0;
    chk("s3_done", done, 2'b10);
    req = 2'b01;
    tick(1);
    chk("s3_fs_grant", grant, 0);
    chk("s3_fs_cmd", bus_cmd(), 5'b01001);
    chk("s3_fs_nodone", done, 0);
    tick(3);
    chk("s3_fs_hold", bus_cmd(), 5'b01001);
    cmd_ack = 1'b1;
    tick(1);
    cmd_ack = 1'b0;
    chk("s3_fs_cleared", bus_cmd(), 0);
    chk("s3_fs_ack_nodone", done, 0);
    tick(4);
    chk("s3_gap_hold", grant, 0);
    tick(1);
    chk("s3_regrant0", grant, 2'b01);

    // Non-owner command ignored, then arbitration lost mid-write
    send(1, 1, 0, 0, 1, 8'h55);
    chk("s5_nonowner_cmd", bus_cmd(), 0);
    chk("s5_nonowner_ready", cmd_ready, 2'b01);
    send(0, 1, 0, 0, 1, 8'h33);
    tick(1);
    cmd_ack = 1'b1;
    tick(1);
    cmd_ack = 1'b0;
    chk("s5_open_done", done, 2'b01);
    send(0, 0, 0, 0, 1, 8'h44);
    chk("s5_cmd", bus_cmd(), 5'b00010);
    tick(1);
    al = 1'b1; cmd_ack = 1'b1;
    tick(1);
    al = 1'b0; cmd_ack = 1'b0;
    chk("s5_al_done", done, 2'b01);
    chk("s5_al_err", err, 1);
    chk("s5_al_cleared", bus_cmd(), 0);
    chk("s5_al_grant", grant, 2'b01);
    tick(1);
    chk("s5_err_pulse", {done, err}, 0);
    chk("s5_ready", cmd_ready, 2'b01);
    // Lost arbitration closed the bus: drop gives GAP, no forced stop.
    req = 2'b00;
    tick(1);
    chk("s5_release_nostop", {grant, stop_o}, 0);

    // Watchdog with bus closed, then with bus open
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    req = 2'b01;
    tick(1);
    chk("s4_grant", grant, 2'b01);
    tick(15);
    chk("s4_pre_timeout", {timeout, grant}, 3'b001);
    tick(1);
    chk("s4_timeout", timeout, 1);
    chk("s4_revoked", grant, 0);
    chk("s4_nostop", stop_o, 0);
    tick(1);
    chk("s4_timeout_pulse", timeout, 0);
    tick(6);
    chk("s4_blocked", grant, 0);
    req = 2'b00;
    tick(1);
    req = 2'b01;
    tick(1);
    chk("s4_unblocked", grant, 2'b01);
    send(0, 1, 0, 0, 1, 8'hE8);
    tick(1);
    cmd_ack = 1'b1;
    tick(1);
    cmd_ack = 1'b0;
    chk("s4_open_done", done, 2'b01);
    tick(15);
    chk("s4b_pre_timeout", {timeout, grant}, 3'b001);
    tick(1);
    chk("s4b_timeout", timeout, 1);
    chk("s4b_fs_cmd", bus_cmd(), 5'b01001);
    chk("s4b_revoked", grant, 0);
    cmd_ack = 1'b1;
    tick(1);
    cmd_ack = 1'b0;
    chk("s4b_fs_cleared", bus_cmd(), 0);
    req = 2'b00;

    // Reset during an issued write
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    req = 2'b01;
    tick(1);
    chk("s6_grant", grant, 2'b01);
    send(0, 0, 0, 0, 1, 8'h77);
    chk("s6_write", write_o, 1);
    rst = 1'b1; req = 2'b11;
    tick(1);
    chk("s6_rst_cmd", bus_cmd(), 0);
    chk("s6_rst_din", din_o, 0);
    chk("s6_rst_grant", {grant, cmd_ready, done}, 0);
    rst = 1'b0;
    tick(1);
    chk("s6_rr_reset", grant, 2'b01);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/i2c_cmd_arbiter.md
Name: i2c_cmd_arbiter

Overview:
- Shares one I2C byte controller between NUM_REQ requesters, e.g. the Si5340 config loader and a status/readback poller.
- Grants bus ownership round-robin and locks the grant for a whole transaction, START through STOP.
- Holds each byte command stable to the byte controller until cmd_ack, then routes the response back to the owner.
- Sits between the requesters and the byte controller; releases the bus itself on owner drop-out or watchdog timeout.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- DATA_WIDTH, 8, I2C byte width.
- TIMEOUT, 1024, max idle cycles in OWNED before the grant is revoked.
- GAP_CYCLES, 4, idle cycles after release before re-arbitration (≥1).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset; synchronous, active-high.
- req_i  in  NUM_REQ  per-requester bus request, level, held for the whole transaction.
- grant_o  out  NUM_REQ  one-hot ownership.
- cmd_ready_o  out  NUM_REQ  owner may present a command.
- cmd_valid_i  in  NUM_REQ  one-cycle command strobe.
- cmd_start_i, cmd_stop_i, cmd_read_i, cmd_write_i, cmd_ack_in_i  in  NUM_REQ each  command fields.
- cmd_din_i  in  NUM_REQ*DATA_WIDTH  write byte; requester k uses bits [k*DATA_WIDTH +: DATA_WIDTH].
- done_o  out  NUM_REQ  one-cycle completion pulse to owner.
- err_o  out  1  valid with done_o: arbitration lost.
- rsp_dout_o  out  DATA_WIDTH  read byte, valid with done_o.
- rsp_ack_o  out  1  slave ACK bit, valid with done_o.
- timeout_o  out  1  one-cycle pulse on watchdog revoke.
- start_o, stop_o, read_o, write_o, ack_in_o  out  1 each  to byte controller.
- din_o  out  DATA_WIDTH  to byte controller.
- cmd_ack_i, ack_out_i, al_i  in  1 each  from byte controller.
- dout_i  in  DATA_WIDTH  from byte controller.

Behaviour:
- Reset: state=IDLE; rr_ptr=0, so requester 0 wins first; bus_open=0; all counters 0.
  - All outputs 0: grant_o, cmd_ready_o, done_o, err_o, timeout_o, rsp_*, and all byte-controller outputs.
  - Reset mid-command drops the command outputs the next cycle. No stop is issued.
- States: IDLE, OWNED, ISSUE, FORCE_STOP, GAP.
- IDLE:
  - If req_i!=0, the winner is the first set bit at or after rr_ptr, circular.
  - Next cycle: grant_o=onehot(winner), rr_ptr=winner+1 mod NUM_REQ, state -> OWNED.
  - Total latency: 1 cycle from req to grant.
- OWNED:
  - cmd_ready_o = grant_o.
  - Owner cmd_valid_i: latch its fields, then drive them on start_o..din_o from the next cycle; state -> ISSUE.
  - cmd_valid_i from non-owners, and in any other state, is ignored.
- ISSUE:
  - Command outputs held constant until cmd_ack_i.
  - On cmd_ack_i: outputs cleared the next cycle.
  - done_o[owner]=1 for one cycle, with rsp_dout_o=dout_i, rsp_ack_o=ack_out_i, err_o=0.
  - bus_open set if the command had start, cleared if it had stop; then -> OWNED.
- al_i during ISSUE (priority over cmd_ack_i):
  - Abort the command; outputs cleared.
  - done_o pulse with err_o=1; bus_open=0; -> OWNED, grant kept.
- Release (evaluated in OWNED only; a req drop during ISSUE completes the command first):
  - req_i[owner]=0 and bus_open=0 -> GAP.
  - req_i[owner]=0 and bus_open=1 -> FORCE_STOP.
  - Release revokes the grant on transition: grant_o=0 in GAP and FORCE_STOP.
- FORCE_STOP:
  - Drive stop_o=1, ack_in_o=1, all other command outputs 0, until cmd_ack_i or al_i.
  - No done_o pulse; bus_open=0; -> GAP.
- Watchdog:
  - Counter runs in OWNED, clears on owner cmd_valid_i and on entering OWNED.
  - When it reaches TIMEOUT: timeout_o pulse, then the same release path as a req drop.
  - Requester must deassert req before it can be re-granted.
- GAP:
  - Count GAP_CYCLES, then -> IDLE.
  - Requests asserted during GAP are arbitrated in IDLE.
- Simultaneous events: a requester raising req while another owns the bus waits; no pre-emption.
- Widths: rr_ptr is $clog2(NUM_REQ) wide and wraps from NUM_REQ-1 to 0. Watchdog is $clog2(TIMEOUT+1) wide.

Test Plan:
- Req0 only: commands {start,write,0xE8}, {write,0x01}, {write,stop,0x0B}, cmd_ack 5 cycles after each -> three done_o[0] pulses; write_o/din_o stable until each ack; bus_open 1 then 0; drop req -> grant_o=0, IDLE after 4 GAP cycles.
- Req0 and req1 asserted same cycle after reset -> grant 0b01 first; after release grant 0b10; both re-asserted -> 0b01 again.
- Req1 drops req after an acked start without stop -> stop_o=1, ack_in_o=1, write_o=0 until cmd_ack; no done_o; then GAP.
- TIMEOUT=16, req0 granted, no cmd_valid -> timeout_o pulse on the 16th idle cycle; grant revoked; force stop if the bus is open.
- al_i during a write command -> done_o[owner] with err_o=1; command outputs 0 next cycle; grant retained.
- rst_i asserted during ISSUE with write_o=1 -> next cycle all outputs 0, state IDLE; next winner is requester 0.
